// File: rtl/iiitb_uart_pkg.sv
// Shared types and constants for the iiitb UART blocks.
// Holds the transmitter state encoding and the parity mode selectors.
package iiitb_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

// File: rtl/iiitb_edge_sync.sv
// Multi-flop synchroniser for an asynchronous level plus a rising-edge detector.
// rise_tick is high for exactly one clk after each synchronised 0->1 transition.
module iiitb_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_tick
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   last_q;
    logic                   last_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        last_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            last_q <= last_d;
        end
    end

    // Both terms are registered, so the tick carries no path from async_in.
    assign rise_tick = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/iiitb_uart_tx.sv
// UART transmitter: serialises latched bytes LSB-first (start, data, optional parity, stop)
// with every line level held from one baud tick to the next.
module iiitb_uart_tx
    import iiitb_uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY      = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_in,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CNT_W = $clog2(DATA_BITS);

    tx_state_e              state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   parity_q, parity_d;
    logic                   tx_q, tx_d;
    logic                   frame_done_q, frame_done_d;
    logic                   baud_tick;

    iiitb_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_baud_sync (
        .clk      (clk),
        .rst_n    (reset),
        .async_in (baud_in),
        .rise_tick(baud_tick)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        parity_d     = parity_q;
        tx_d         = tx_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (tx_valid) begin
                    shift_d  = tx_data;
                    // Parity is fixed at handshake time from the byte being sent.
                    parity_d = (PARITY == PAR_ODD) ? ~(^tx_data) : (^tx_data);
                    state_d  = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        if (PARITY != PAR_NONE) begin
                            tx_d    = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = ST_STOP;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            parity_q     <= 1'b0;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            parity_q     <= parity_d;
            tx_q         <= tx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx         = tx_q;
    assign frame_done = frame_done_q;
    assign tx_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iiitb_uart_tx.sv
// Directed bench for iiitb_uart_tx: four instances (8N1, even parity, odd parity, two stop bits)
// share clock, reset, baud and data; tx line is sampled mid baud period and checked per tick.
module tb_iiitb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_in;
    logic [7:0] tx_data;
    logic [3:0] valid_v;
    logic [3:0] ready_v;
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [3:0] fd_v;
    int         fd_cnt [4];
    int         n_checks = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    iiitb_uart_tx u_dut_8n1 (
        .clk(clk), .reset(reset), .baud_in(baud_in), .tx_data(tx_data),
        .tx_valid(valid_v[0]), .tx_ready(ready_v[0]), .tx(tx_v[0]),
        .busy(busy_v[0]), .frame_done(fd_v[0])
    );

    iiitb_uart_tx #(.PARITY(1)) u_dut_even (
        .clk(clk), .reset(reset), .baud_in(baud_in), .tx_data(tx_data),
        .tx_valid(valid_v[1]), .tx_ready(ready_v[1]), .tx(tx_v[1]),
        .busy(busy_v[1]), .frame_done(fd_v[1])
    );

    iiitb_uart_tx #(.PARITY(2)) u_dut_odd (
        .clk(clk), .reset(reset), .baud_in(baud_in), .tx_data(tx_data),
        .tx_valid(valid_v[2]), .tx_ready(ready_v[2]), .tx(tx_v[2]),
        .busy(busy_v[2]), .frame_done(fd_v[2])
    );

    iiitb_uart_tx #(.STOP_BITS(2)) u_dut_s2 (
        .clk(clk), .reset(reset), .baud_in(baud_in), .tx_data(tx_data),
        .tx_valid(valid_v[3]), .tx_ready(ready_v[3]), .tx(tx_v[3]),
        .busy(busy_v[3]), .frame_done(fd_v[3])
    );

    // Pulse counters settle 1 time unit after each posedge, well before the negedge samples.
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 4; k++) begin
            if (fd_v[k] === 1'b1) fd_cnt[k] = fd_cnt[k] + 1;
        end
    end

    // One 16-clk baud period starting at a negedge; samples all tx lines 7 clk after the rise.
    task automatic baud_period(output logic [3:0] s);
        baud_in = 1'b1;
        repeat (7) @(negedge clk);
        s = tx_v;
        baud_in = 1'b0;
        repeat (9) @(negedge clk);
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        baud_in = 1'b0;
        tx_data = 8'h00;
        valid_v = 4'h0;
        for (int c = 0; c < 95; c++) begin
            baud_in = ((c % 16) < 8);
            @(negedge clk);
        end
        n_checks++;
        if ({tx_v, ready_v, busy_v, fd_v} !== {4'hF, 4'hF, 4'h0, 4'h0})
            $display("FAIL reset_state: tx/ready/busy/fd got %b/%b/%b/%b want 1111/1111/0000/0000",
                     tx_v, ready_v, busy_v, fd_v);
        else n_pass++;
        reset = 1'b1;
        for (int c = 0; c < 96; c++) begin
            baud_in = ((c % 16) < 8);
            @(negedge clk);
            n_checks++;
            if ({tx_v, ready_v, busy_v} !== {4'hF, 4'hF, 4'h0})
                $display("FAIL idle_cycle%0d: tx/ready/busy got %b/%b/%b want 1111/1111/0000",
                         c, tx_v, ready_v, busy_v);
            else n_pass++;
        end
        baud_in = 1'b0;
        n_checks++;
        if (fd_cnt[0] + fd_cnt[1] + fd_cnt[2] + fd_cnt[3] !== 0)
            $display("FAIL idle_frame_done: got %0d pulses want 0",
                     fd_cnt[0] + fd_cnt[1] + fd_cnt[2] + fd_cnt[3]);
        else n_pass++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_default_frame();
        logic [0:10] exp_seq;
        logic [3:0]  s;
        int          fd0;
        exp_seq = 11'b01010010111;
        fd0 = fd_cnt[0];
        tx_data    = 8'hA5;
        valid_v[0] = 1'b1;
        @(negedge clk);
        valid_v[0] = 1'b0;
        n_checks++;
        if ({tx_v[0], ready_v[0], busy_v[0]} !== 3'b101)
            $display("FAIL 8n1_align: tx/ready/busy got %b%b%b want 101", tx_v[0], ready_v[0], busy_v[0]);
        else n_pass++;
        for (int i = 0; i < 11; i++) begin
            baud_period(s);
            n_checks++;
            if (s[0] !== exp_seq[i])
                $display("FAIL 8n1_tick%0d: tx got %b want %b", i + 1, s[0], exp_seq[i]);
            else n_pass++;
        end
        n_checks++;
        if (fd_cnt[0] - fd0 !== 1)
            $display("FAIL 8n1_frame_done: got %0d pulses want 1", fd_cnt[0] - fd0);
        else n_pass++;
        n_checks++;
        if ({ready_v[0], busy_v[0]} !== 2'b10)
            $display("FAIL 8n1_end: ready/busy got %b%b want 10", ready_v[0], busy_v[0]);
        else n_pass++;
    endtask

    task automatic test_parity();
        logic [0:11] exp_even;
        logic [0:11] exp_odd;
        logic [0:11] exp_even07;
        logic [3:0]  s;
        int          fd1;
        int          fd2;
        exp_even   = 12'b010100101011;
        exp_odd    = 12'b010100101111;
        exp_even07 = 12'b011100000111;
        fd1 = fd_cnt[1];
        fd2 = fd_cnt[2];
        tx_data    = 8'hA5;
        valid_v[1] = 1'b1;
        valid_v[2] = 1'b1;
        @(negedge clk);
        valid_v[1] = 1'b0;
        valid_v[2] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            baud_period(s);
            n_checks++;
            if (s[1] !== exp_even[i])
                $display("FAIL even_a5_tick%0d: tx got %b want %b", i + 1, s[1], exp_even[i]);
            else n_pass++;
            n_checks++;
            if (s[2] !== exp_odd[i])
                $display("FAIL odd_a5_tick%0d: tx got %b want %b", i + 1, s[2], exp_odd[i]);
            else n_pass++;
        end
        tx_data    = 8'h07;
        valid_v[1] = 1'b1;
        @(negedge clk);
        valid_v[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            baud_period(s);
            n_checks++;
            if (s[1] !== exp_even07[i])
                $display("FAIL even_07_tick%0d: tx got %b want %b", i + 1, s[1], exp_even07[i]);
            else n_pass++;
        end
        n_checks++;
        if ((fd_cnt[1] - fd1 !== 2) || (fd_cnt[2] - fd2 !== 1))
            $display("FAIL parity_frame_done: even/odd got %0d/%0d want 2/1",
                     fd_cnt[1] - fd1, fd_cnt[2] - fd2);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [0:23] exp_seq;
        logic [3:0]  s;
        int          fd3;
        exp_seq = 24'b010101010111011110000111;
        fd3 = fd_cnt[3];
        tx_data    = 8'h55;
        valid_v[3] = 1'b1;
        @(negedge clk);
        tx_data = 8'h0F;
        n_checks++;
        if (ready_v[3] !== 1'b0)
            $display("FAIL b2b_first_accept: ready got %b want 0", ready_v[3]);
        else n_pass++;
        for (int i = 0; i < 24; i++) begin
            baud_period(s);
            if (i == 12) valid_v[3] = 1'b0;
            n_checks++;
            if (s[3] !== exp_seq[i])
                $display("FAIL b2b_tick%0d: tx got %b want %b", i + 1, s[3], exp_seq[i]);
            else n_pass++;
        end
        n_checks++;
        if (fd_cnt[3] - fd3 !== 2)
            $display("FAIL b2b_frame_done: got %0d pulses want 2", fd_cnt[3] - fd3);
        else n_pass++;
        baud_period(s);
        n_checks++;
        if ({s[3], busy_v[3]} !== 2'b10)
            $display("FAIL b2b_no_extra_frame: tx/busy got %b%b want 10", s[3], busy_v[3]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [0:4] exp_seq;
        logic [3:0] s;
        int         fd0;
        exp_seq = 5'b01010;
        fd0 = fd_cnt[0];
        tx_data    = 8'hA5;
        valid_v[0] = 1'b1;
        @(negedge clk);
        valid_v[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            baud_period(s);
            n_checks++;
            if (s[0] !== exp_seq[i])
                $display("FAIL rst_pre_tick%0d: tx got %b want %b", i + 1, s[0], exp_seq[i]);
            else n_pass++;
        end
        n_checks++;
        if (tx_v[0] !== 1'b0)
            $display("FAIL rst_bit3_level: tx got %b want 0", tx_v[0]);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({tx_v[0], ready_v[0], busy_v[0]} !== 3'b110)
            $display("FAIL rst_async: tx/ready/busy got %b%b%b want 110", tx_v[0], ready_v[0], busy_v[0]);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            baud_period(s);
            n_checks++;
            if ({s[0], busy_v[0]} !== 2'b10)
                $display("FAIL rst_after_tick%0d: tx/busy got %b%b want 10", i + 1, s[0], busy_v[0]);
            else n_pass++;
        end
        n_checks++;
        if (fd_cnt[0] - fd0 !== 0)
            $display("FAIL rst_frame_done: got %0d pulses want 0", fd_cnt[0] - fd0);
        else n_pass++;
    endtask

    task automatic test_stalled_baud();
        logic [0:10] exp_seq;
        logic [3:0]  s;
        int          fd0;
        exp_seq = 11'b00011110011;
        fd0 = fd_cnt[0];
        baud_in    = 1'b0;
        tx_data    = 8'h3C;
        valid_v[0] = 1'b1;
        @(negedge clk);
        valid_v[0] = 1'b0;
        repeat (60) @(negedge clk);
        n_checks++;
        if ({tx_v[0], ready_v[0], busy_v[0]} !== 3'b101)
            $display("FAIL stall_hold: tx/ready/busy got %b%b%b want 101", tx_v[0], ready_v[0], busy_v[0]);
        else n_pass++;
        for (int i = 0; i < 11; i++) begin
            baud_period(s);
            n_checks++;
            if (s[0] !== exp_seq[i])
                $display("FAIL stall_tick%0d: tx got %b want %b", i + 1, s[0], exp_seq[i]);
            else n_pass++;
        end
        n_checks++;
        if (fd_cnt[0] - fd0 !== 1)
            $display("FAIL stall_frame_done: got %0d pulses want 1", fd_cnt[0] - fd0);
        else n_pass++;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) fd_cnt[k] = 0;
        test_reset();
        test_default_frame();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_stalled_baud();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
